// File: rtl/exec_sequencer_if.sv
// Handshake/bus bundle between the multicycle control sequencer and its datapath.
// Latency: none (wires only). Backpressure: memory stalls are carried by mem_ready.
// Ports: sequencing controls, IR opcode, memory handshake, ALU flag, datapath strobes/selects, status.
interface exec_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic             halt;
   logic [5:0]       opcode;
   logic             mem_ready;
   logic             zero;
   logic             ir_write;
   logic             pc_write;
   logic             pc_write_cond;
   logic             mem_read;
   logic             mem_write;
   logic             reg_write;
   logic             alu_src;
   logic             regDst;
   logic             mem_to_reg;
   logic             jump;
   logic [2:0]       alu_op;
   logic             busy;
   logic             retire;
   logic             illegal;
   logic [CNT_W-1:0] retired_cnt;

   // The datapath/testbench drives the controls and observes the strobes.
   modport master (
      output start, halt, opcode, mem_ready, zero,
      input  ir_write, pc_write, pc_write_cond, mem_read, mem_write, reg_write,
      input  alu_src, regDst, mem_to_reg, jump, alu_op, busy, retire, illegal, retired_cnt
   );

   // The sequencer consumes the controls and produces the strobes.
   modport slave (
      input  start, halt, opcode, mem_ready, zero,
      output ir_write, pc_write, pc_write_cond, mem_read, mem_write, reg_write,
      output alu_src, regDst, mem_to_reg, jump, alu_op, busy, retire, illegal, retired_cnt
   );
endinterface

// File: rtl/exec_sequencer.sv
// Multicycle control FSM (IDLE/FETCH/DECODE/EXECUTE/MEM/WB) with a retired-instruction counter.
// Latency: 3 cycles (beq/j), 4 cycles (R-type/addi/sw), 5 cycles (lw) per instruction with no stalls.
// Backpressure: FETCH and MEM hold their access strobes until mem_ready=1.
// Ports: clk, rst_n (async active-low); bus = exec_sequencer_if.slave.
module exec_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   exec_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_t           r_state;
   state_t           w_next;
   logic [5:0]       r_op;
   logic [CNT_W-1:0] r_cnt;

   logic       w_ir_write, w_pc_write, w_pc_write_cond, w_mem_read, w_mem_write, w_reg_write;
   logic       w_alu_src, w_reg_dst, w_mem_to_reg, w_jump, w_retire, w_illegal;
   logic [2:0] w_alu_op;
   logic       w_legal;

   always_comb begin
      w_legal = (bus.opcode == OP_RTYPE) || (bus.opcode == OP_LW)   ||
                (bus.opcode == OP_SW)    || (bus.opcode == OP_BEQ)  ||
                (bus.opcode == OP_ADDI)  || (bus.opcode == OP_J);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_op    <= 6'd0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         // The IR opcode is stable from DECODE onward, so capture it once here.
         if (r_state == S_DECODE) r_op <= bus.opcode;
         if (w_retire) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_comb begin
      w_next          = r_state;
      w_ir_write      = 1'b0;
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_reg_write     = 1'b0;
      w_alu_src       = 1'b0;
      w_reg_dst       = 1'b0;
      w_mem_to_reg    = 1'b0;
      w_jump          = 1'b0;
      w_alu_op        = 3'b000;
      w_retire        = 1'b0;
      w_illegal       = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (bus.start) w_next = S_FETCH;
         end
         S_FETCH: begin
            w_mem_read = 1'b1;
            if (bus.mem_ready) begin
               w_ir_write = 1'b1;
               w_pc_write = 1'b1;
               w_next     = S_DECODE;
            end
         end
         S_DECODE: begin
            // op_q is not loaded yet, so legality is judged on the live opcode.
            if (w_legal) begin
               w_next = S_EXECUTE;
            end else begin
               w_illegal = 1'b1;
               w_next    = bus.halt ? S_IDLE : S_FETCH;
            end
         end
         S_EXECUTE: begin
            case (r_op)
               OP_RTYPE: begin
                  w_alu_op = 3'b010;
                  w_next   = S_WB;
               end
               OP_ADDI: begin
                  w_alu_src = 1'b1;
                  w_next    = S_WB;
               end
               OP_LW, OP_SW: begin
                  w_alu_src = 1'b1;
                  w_next    = S_MEM;
               end
               OP_BEQ: begin
                  w_alu_op        = 3'b001;
                  w_pc_write_cond = 1'b1;
                  w_pc_write      = bus.zero;
                  w_retire        = 1'b1;
               end
               OP_J: begin
                  w_jump     = 1'b1;
                  w_pc_write = 1'b1;
                  w_retire   = 1'b1;
               end
               default: w_next = S_IDLE;  // unreachable: only legal opcodes reach EXECUTE
            endcase
         end
         S_MEM: begin
            if (r_op == OP_LW) w_mem_read  = 1'b1;
            else               w_mem_write = 1'b1;
            if (bus.mem_ready) begin
               if (r_op == OP_LW) w_next   = S_WB;
               else               w_retire = 1'b1;
            end
         end
         S_WB: begin
            w_reg_write  = 1'b1;
            w_reg_dst    = (r_op == OP_RTYPE);
            w_mem_to_reg = (r_op == OP_LW);
            w_retire     = 1'b1;
         end
         default: w_next = S_IDLE;
      endcase

      // Every retire path shares the halt decision.
      if (w_retire) w_next = bus.halt ? S_IDLE : S_FETCH;
   end

   assign bus.ir_write      = w_ir_write;
   assign bus.pc_write      = w_pc_write;
   assign bus.pc_write_cond = w_pc_write_cond;
   assign bus.mem_read      = w_mem_read;
   assign bus.mem_write     = w_mem_write;
   assign bus.reg_write     = w_reg_write;
   assign bus.alu_src       = w_alu_src;
   assign bus.regDst        = w_reg_dst;
   assign bus.mem_to_reg    = w_mem_to_reg;
   assign bus.jump          = w_jump;
   assign bus.alu_op        = w_alu_op;
   assign bus.busy          = (r_state != S_IDLE);
   assign bus.retire        = w_retire;
   assign bus.illegal       = w_illegal;
   assign bus.retired_cnt   = r_cnt;

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter CNT_W, default 16, width of retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  begin sequencing; sampled in IDLE only.
REQ-005 halt  input  1  stop request; honoured at instruction retire.
REQ-006 opcode  input  6  instruction[31:26] from IR; stable from DECODE until retire.
REQ-007 mem_ready  input  1  memory handshake; access completes in a cycle where it is 1.
REQ-008 zero  input  1  ALU zero flag from execute stage.
REQ-009 ir_write, pc_write, pc_write_cond, mem_read, mem_write, reg_write  output  1 each  datapath strobes.
REQ-010 alu_src, regDst, mem_to_reg, jump  output  1 each  datapath mux selects.
REQ-011 alu_op  output  3  ALU control class to ALU control decoder.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 retire  output  1  one-cycle pulse when an instruction completes.
REQ-014 illegal  output  1  one-cycle pulse on unsupported opcode.
REQ-015 retired_cnt  output  CNT_W  count of retired instructions.

Function
REQ-016 States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB; state and op_q registered; all outputs combinational from state and op_q only (Moore), except ir_write/pc_write in FETCH and mem_read/mem_write qualification below.
REQ-017 Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010; op_q loaded from opcode on the DECODE cycle.
REQ-018 IDLE: all strobes 0; start=1 -> FETCH next cycle; start=0 -> stay.
REQ-019 FETCH: mem_read=1 every cycle; ir_write=pc_write=1 only in the cycle mem_ready=1, then -> DECODE; mem_ready=0 -> stay, no strobe.
REQ-020 DECODE: exactly one cycle; supported opcode -> EXECUTE; unsupported -> illegal=1, no retire, no counter change, -> FETCH (or IDLE if halt=1).
REQ-021 EXECUTE alu_op: 000 (add) for lw/sw/addi, 001 (sub) for beq, 010 (funct) for R-type, 000 for j; alu_src=1 for lw/sw/addi, else 0.
REQ-022 EXECUTE beq: pc_write_cond=1, pc_write=zero; j: jump=1, pc_write=1; both retire here, one cycle.
REQ-023 EXECUTE R-type/addi -> WB; lw/sw -> MEM; one cycle each.
REQ-024 MEM: lw mem_read=1, sw mem_write=1, held every cycle until mem_ready=1; sw retires on that cycle; lw -> WB.
REQ-025 WB: reg_write=1 one cycle; regDst=1 for R-type only; mem_to_reg=1 for lw only; retires.
REQ-026 At retire: retire=1, retired_cnt increments by 1 modulo 2^CNT_W (all-ones wraps to 0); next state IDLE if halt=1 that cycle, else FETCH.
REQ-027 halt outside a retire/illegal cycle has no effect; start outside IDLE ignored; start and halt both 1 in IDLE -> FETCH.
REQ-028 No strobe (ir_write, pc_write, pc_write_cond, mem_read, mem_write, reg_write) asserted in IDLE or DECODE.
REQ-029 Strobes not listed for a state/opcode SHALL be 0; mux selects default 0.

Reset
REQ-030 rst_n=0 immediately forces IDLE, op_q=0, retired_cnt=0, all outputs 0, regardless of clock or current state.
REQ-031 Reset mid-access (FETCH/MEM waiting on mem_ready) abandons access; no retire pulse, no counter increment.
REQ-032 After rst_n deasserts, first transition requires start=1 sampled on a rising edge.

Verification
REQ-033 Reset release, start=1, opcode=000000, mem_ready=1 always -> FETCH,DECODE,EXECUTE(alu_op=010),WB(reg_write=1,regDst=1); retire at cycle 4; retired_cnt=1.
REQ-034 lw with mem_ready low 3 cycles in MEM -> mem_read held 3+1 cycles, then WB with mem_to_reg=1; sw same wait -> mem_write held, retire in MEM, no reg_write.
REQ-035 beq with zero=1 -> pc_write=1, pc_write_cond=1, alu_op=001; with zero=0 -> pc_write=0; both retire in EXECUTE, next FETCH.
REQ-036 opcode=111111 -> illegal pulse in DECODE, retired_cnt unchanged, next FETCH.
REQ-037 CNT_W=4, retired_cnt=15, one addi retires -> retired_cnt=0; halt=1 at that retire -> IDLE, busy=0.
REQ-038 rst_n pulsed low during MEM wait of sw -> outputs 0 asynchronously, no mem_write after release, retired_cnt=0.
